// File: rtl/ex_io_pkg.sv
// Shared EX_IO link definitions: bit positions on the 5-wire header and controller state encodings.
// The game-board receiver imports this package as well.
package ex_io_pkg;
  localparam int EXIO_BURST     = 0;
  localparam int EXIO_SPEED_LSB = 1;
  localparam int EXIO_SPEED_W   = 3;
  localparam int EXIO_START     = 4;

  typedef enum logic {LINK_IDLE, LINK_RUN} link_state_t;
  typedef enum logic [1:0] {BT_IDLE, BT_HOLD, BT_GAP} burst_state_t;
endpackage

// File: rtl/ex_io_burst_timer.sv
// Burst pulse stretcher: HOLD_CYC cycles high, then HOLD_CYC cycles of enforced low gap.
// Requests are accepted only while idle and not cleared; others pulse o_drop one cycle later.
module ex_io_burst_timer
  import ex_io_pkg::*;
#(
  parameter int HOLD_CYC = 5_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_req,
  output logic o_burst,
  output logic o_busy,
  output logic o_drop
);
  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);

  burst_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          burst_q, busy_q, drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = i_req && (i_clr || (state_q != BT_IDLE));
    case (state_q)
      BT_IDLE: begin
        if (i_req && !i_clr) begin
          state_d = BT_HOLD;
          cnt_d   = '0;
        end
      end
      BT_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BT_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BT_GAP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BT_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = BT_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Clear truncates any hold or gap in progress
    if (i_clr) begin
      state_d = BT_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= BT_IDLE;
      cnt_q   <= '0;
      burst_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= (state_d == BT_HOLD);
      busy_q  <= (state_d != BT_IDLE);
      drop_q  <= drop_d;
    end
  end

  assign o_burst = burst_q;
  assign o_busy  = busy_q;
  assign o_drop  = drop_q;
endmodule

// File: rtl/ex_io_link_tx.sv
// EX_IO link transmitter: turns player strobes into registered start/speed/burst link levels.
// Speed is the saturated tap count of the previous window, updated only on window wrap.
module ex_io_link_tx
  import ex_io_pkg::*;
#(
  parameter int WINDOW_CYC     = 25_000_000,
  parameter int BURST_HOLD_CYC = 5_000,
  parameter int SPEED_W        = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_req,
  input  logic       i_stop_req,
  input  logic       i_tap,
  input  logic       i_burst_req,
  output logic [4:0] o_ex_io,
  output logic       o_burst_busy,
  output logic       o_drop
);
  localparam int WW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam logic [WW-1:0]      WIN_LAST = WW'(WINDOW_CYC - 1);
  localparam logic [SPEED_W-1:0] TAP_MAX  = '1;

  link_state_t        link_q, link_d;
  logic [WW-1:0]      win_q, win_d;
  logic [SPEED_W-1:0] tap_q, tap_d, tap_sum;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               start_q;
  logic               bt_clr, bt_burst;

  always_comb begin
    link_d  = link_q;
    win_d   = win_q;
    tap_d   = tap_q;
    speed_d = speed_q;
    tap_sum = (i_tap && (tap_q != TAP_MAX)) ? tap_q + 1'b1 : tap_q;
    case (link_q)
      LINK_IDLE: begin
        win_d   = '0;
        tap_d   = '0;
        speed_d = '0;
        if (i_start_req && !i_stop_req) link_d = LINK_RUN;
      end
      LINK_RUN: begin
        if (i_stop_req) begin
          link_d  = LINK_IDLE;
          win_d   = '0;
          tap_d   = '0;
          speed_d = '0;
        end else if (win_q == WIN_LAST) begin
          // A tap on the wrap cycle still belongs to the closing window
          win_d   = '0;
          tap_d   = '0;
          speed_d = tap_sum;
        end else begin
          win_d = win_q + 1'b1;
          tap_d = tap_sum;
        end
      end
      default: link_d = LINK_IDLE;
    endcase
  end

  assign bt_clr = (link_q == LINK_IDLE) || i_stop_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      link_q  <= LINK_IDLE;
      win_q   <= '0;
      tap_q   <= '0;
      speed_q <= '0;
      start_q <= 1'b0;
    end else begin
      link_q  <= link_d;
      win_q   <= win_d;
      tap_q   <= tap_d;
      speed_q <= speed_d;
      start_q <= (link_d == LINK_RUN);
    end
  end

  ex_io_burst_timer #(
    .HOLD_CYC(BURST_HOLD_CYC)
  ) u_burst (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (bt_clr),
    .i_req  (i_burst_req),
    .o_burst(bt_burst),
    .o_busy (o_burst_busy),
    .o_drop (o_drop)
  );

  assign o_ex_io[EXIO_BURST]                          = bt_burst;
  assign o_ex_io[EXIO_SPEED_LSB +: EXIO_SPEED_W]      = speed_q;
  assign o_ex_io[EXIO_START]                          = start_q;
endmodule

// File: tb/tb_ex_io_link_tx.sv
// Bench for ex_io_link_tx: cycle-level reference model feeds an expectation queue,
// a negedge monitor compares every registered output against it.
module tb_ex_io_link_tx;
  localparam int WIN  = 100;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst, start, stop, tap, breq;
  logic [4:0] ex_io;
  logic       busy, drop;

  typedef struct packed {
    logic [4:0] ex;
    logic       busy;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_cyc = 0;

  always #5 clk = ~clk;

  ex_io_link_tx #(
    .WINDOW_CYC(WIN),
    .BURST_HOLD_CYC(HOLD),
    .SPEED_W(3)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start_req (start),
    .i_stop_req  (stop),
    .i_tap       (tap),
    .i_burst_req (breq),
    .o_ex_io     (ex_io),
    .o_burst_busy(busy),
    .o_drop      (drop)
  );

  // Reference model: game running flag, time since start, tap tally, time of last accepted burst.
  initial begin : model
    longint n = 0;
    longint start_t = 0;
    longint acc_t = 0;
    longint el, pos;
    bit     running = 0;
    bit     acc_vld = 0;
    int     taps = 0;
    int     speed = 0;
    bit     d;
    bit     b_exp, busy_exp;
    exp_t   e;
    forever begin
      @(posedge clk);
      d = 0;
      if (rst) begin
        running = 0; acc_vld = 0; taps = 0; speed = 0;
      end else if (running) begin
        if (stop) begin
          running = 0; speed = 0; acc_vld = 0; taps = 0;
          d = breq;
        end else begin
          pos = n - start_t - 1;
          taps += int'(tap);
          if (pos % WIN == WIN - 1) begin
            speed = (taps > 7) ? 7 : taps;
            taps = 0;
          end
          if (breq) begin
            if (!acc_vld || (n - acc_t) >= 2 * HOLD + 1) begin
              acc_vld = 1; acc_t = n;
            end else begin
              d = 1;
            end
          end
        end
      end else begin
        d = breq;
        if (start && !stop) begin
          running = 1; start_t = n; taps = 0; speed = 0;
        end
      end
      el = n + 1 - acc_t;
      b_exp    = running && acc_vld && el >= 1 && el <= HOLD;
      busy_exp = running && acc_vld && el >= 1 && el <= 2 * HOLD;
      e.ex   = {running, 3'(speed), b_exp};
      e.busy = busy_exp;
      e.drop = d;
      exp_q.push_back(e);
      n++;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ex_io !== e.ex) begin
          n_bad++;
          $display("FAIL ex_io cyc=%0d got=%b exp=%b", mon_cyc, ex_io, e.ex);
        end
        n_cmp++;
        if (busy !== e.busy) begin
          n_bad++;
          $display("FAIL burst_busy cyc=%0d got=%b exp=%b", mon_cyc, busy, e.busy);
        end
        n_cmp++;
        if (drop !== e.drop) begin
          n_bad++;
          $display("FAIL drop cyc=%0d got=%b exp=%b", mon_cyc, drop, e.drop);
        end
        mon_cyc++;
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic p, input logic t, input logic b);
    rst = r; start = s; stop = p; tap = t; breq = b;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : stim
    int tw[5] = '{3, 12, 0, 2, 0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; tap = 1'b0; breq = 1'b0;

    // Reset with strobes toggling
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Windows: 3 taps, 12 taps (saturate), none, 2 taps plus one on the wrap cycle, none
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < WIN; i++)
        step(1'b0, 1'b0, 1'b0,
             ((i % 8 == 0) && (i / 8 < tw[w])) || (w == 3 && i == WIN - 1), 1'b0);

    // Burst hold/gap, drops mid-gap and on the last gap cycle, accept right after
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);

    // Stop on the second hold cycle, then restart and burst again
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);

    // Start and stop together, in RUN and then in IDLE
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Bursts and taps while idle
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 1'(i % 2), 1'(i % 3 == 0));
    idle(3);

    // Randomized traffic with rare resets and stops
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 599) == 0),
           1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 999) < 3),
           1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 10));
    idle(3);

    n_cmp++;
    if (exp_q.size() > 1) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp<=1", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
